// File: rtl/mul_pkg.sv
// mul_pkg: shared state type and datapath constants for the multiplier stages
package mul_pkg;
    typedef enum logic {ST_ACCUM, ST_HOLD} state_t;
    localparam int PROD_W = 64;
    localparam int Q_W = 32;
    localparam logic [Q_W-1:0] Q_MAX = 32'h7FFF_FFFF;
    localparam logic [Q_W-1:0] Q_MIN = 32'h8000_0000;
endpackage

// File: rtl/mul_round_sat.sv
// mul_round_sat: round-half-up arithmetic shift of a signed sum, saturated to Q_W bits
// ports: acc (ACC_W signed sum in), q (Q_W saturated result), sat (q was clipped)
module mul_round_sat
    import mul_pkg::*;
#(
    parameter int ACC_W = 72,
    parameter int SHIFT = 16
) (
    input  logic [ACC_W-1:0] acc,
    output logic [Q_W-1:0]   q,
    output logic             sat
);
    localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(SHIFT > 0) << (SHIFT > 0 ? SHIFT - 1 : 0);
    logic signed [ACC_W:0] r;
    always_comb begin
        r = ($signed({acc[ACC_W-1], acc}) + HALF) >>> SHIFT;
        // r fits in Q_W only if every bit from the Q_W sign bit upward agrees
        sat = !(&r[ACC_W:Q_W-1] || ~|r[ACC_W:Q_W-1]);
        q = sat ? (r[ACC_W] ? Q_MIN : Q_MAX) : r[Q_W-1:0];
    end
endmodule

// File: rtl/mul_product_accumulator.sv
// mul_product_accumulator: sums signed 64-bit products, emits full and rounded/saturated results
// ports: clk/rst/clr control; in_* product handshake with last tag;
//        out_* held result: out_acc full sum, out_q rounded, out_count terms, out_sat, out_ovf
module mul_product_accumulator
    import mul_pkg::*;
#(
    parameter int ACC_W = 72,
    parameter int SHIFT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [Q_W-1:0]    out_q,
    output logic [7:0]        out_count,
    output logic              out_sat,
    output logic              out_ovf
);
    state_t state, state_nx;
    logic [ACC_W-1:0] acc, prod, sum;
    logic [7:0] count, count_nx;
    logic ovf, ovf_nx, accept, drain, sat;
    logic [Q_W-1:0] q;
    always_comb begin
        prod = {{(ACC_W-PROD_W){in_product[PROD_W-1]}}, in_product};
        sum = acc + prod;
        // signed overflow: operands share a sign that the sum does not
        ovf_nx = ovf || (acc[ACC_W-1] == prod[ACC_W-1] && sum[ACC_W-1] != acc[ACC_W-1]);
        count_nx = count == 8'hFF ? count : count + 8'd1;
        in_ready = !clr && (state == ST_ACCUM || out_ready);
        accept = in_valid && in_ready;
        drain = state == ST_HOLD && out_ready;
        state_nx = accept && in_last ? ST_HOLD : drain ? ST_ACCUM : state;
        out_valid = state == ST_HOLD;
    end
    mul_round_sat #(.ACC_W(ACC_W), .SHIFT(SHIFT)) u_round (.acc(sum), .q(q), .sat(sat));
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ACCUM;
            acc <= '0;
            count <= '0;
            ovf <= 1'b0;
            out_acc <= '0;
            out_q <= '0;
            out_count <= '0;
            out_sat <= 1'b0;
            out_ovf <= 1'b0;
        end else begin
            state <= state_nx;
            if (clr || (accept && in_last)) begin
                acc <= '0;
                count <= '0;
                ovf <= 1'b0;
            end else if (accept) begin
                acc <= sum;
                count <= count_nx;
                ovf <= ovf_nx;
            end
            if (accept && in_last) begin
                out_acc <= sum;
                out_q <= q;
                out_count <= count_nx;
                out_sat <= sat;
                out_ovf <= ovf_nx;
            end
        end
    end
endmodule
